// File: rtl/maxpool_line_cache_kxs_if.sv
// Stream bundle for the K x K max-pool line cache: raster input side and pooled output side.
// The slave modport is the pooling block; the master modport is whoever feeds and drains it.
interface maxpool_line_cache_kxs_if #(
   parameter int WIDTH_D = 27
);
   logic               i_vsync;
   logic               i_hsync;
   logic               i_valid;
   logic [WIDTH_D-1:0] i_tdata;
   logic               o_vsync;
   logic               o_hsync;
   logic               o_valid;
   logic [WIDTH_D-1:0] o_tdata;

   modport master (
      output i_vsync, i_hsync, i_valid, i_tdata,
      input  o_vsync, o_hsync, o_valid, o_tdata
   );

   modport slave (
      input  i_vsync, i_hsync, i_valid, i_tdata,
      output o_vsync, o_hsync, o_valid, o_tdata
   );
endinterface

// File: rtl/maxpool_line_cache_kxs.sv
// Streaming K x K / stride S max-pool over a channel-interleaved raster map.
// K-1 cascaded line RAMs form the vertical max; a per-channel stash forms the horizontal max.
module maxpool_line_cache_kxs #(
   parameter int WIDTH_D = 27,
   parameter int SIZE    = 14,
   parameter int CHANNEL = 256,
   parameter int K       = 2,
   parameter int S       = 2,
   parameter int SIGNED  = 1
) (
   input  logic                     i_sclk,
   input  logic                     i_rstn,
   maxpool_line_cache_kxs_if.slave  io
);

   localparam int DEPTH = SIZE * CHANNEL;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
   localparam int LW    = $clog2(SIZE + 1);
   localparam int RW    = LW + 1;

   localparam logic [CW-1:0] CH_LAST  = CW'(CHANNEL - 1);
   localparam logic [LW-1:0] COL_END  = LW'(SIZE);
   localparam logic [RW-1:0] ROW_END  = RW'(SIZE);
   localparam logic [RW-1:0] ROW_PRE  = {RW{1'b1}};
   localparam logic [LW-1:0] KM1_C    = LW'(K - 1);
   localparam logic [RW-1:0] KM1_R    = RW'(K - 1);

   if (!(K == 2 || K == 3) || !(S == 1 || S == 2) || SIZE < K) begin : g_param_bad
      $error("maxpool_line_cache_kxs: K must be 2/3, S must be 1/2, SIZE must be >= K");
   end

   function automatic logic [WIDTH_D-1:0] mx(input logic [WIDTH_D-1:0] a,
                                             input logic [WIDTH_D-1:0] b);
      logic gt;
      if (SIGNED != 0) gt = ($signed(a) > $signed(b));
      else             gt = (a > b);
      return gt ? a : b;
   endfunction

   // ---------------- input counters ----------------
   logic          active_q, active_d;
   logic [RW-1:0] row_q, row_d;
   logic [LW-1:0] col_q, col_d;
   logic [CW-1:0] ch_q, ch_d;

   logic          act_e;
   logic [RW-1:0] row_e, row_diff;
   logic [LW-1:0] col_e, col_diff;
   logic [CW-1:0] ch_e;
   logic          acc, emit, hs_first;
   logic [AW-1:0] addr;

   // Row pre-state ROW_PRE sits above SIZE so words before the first i_hsync are dropped.
   always_comb begin
      row_e = row_q;
      col_e = col_q;
      ch_e  = ch_q;
      act_e = active_q;
      if (io.i_vsync) begin
         act_e = 1'b1;
         row_e = io.i_valid ? '0 : ROW_PRE;
         col_e = '0;
         ch_e  = '0;
      end else if (io.i_hsync) begin
         if (row_q != ROW_END) row_e = row_q + RW'(1);
         col_e = '0;
         ch_e  = '0;
      end

      acc = io.i_valid && act_e && (row_e < ROW_END) && (col_e < COL_END);

      active_d = act_e;
      row_d    = row_e;
      col_d    = col_e;
      ch_d     = ch_e;
      if (acc) begin
         if (ch_e == CH_LAST) begin
            ch_d  = '0;
            col_d = col_e + LW'(1);
         end else begin
            ch_d  = ch_e + CW'(1);
         end
      end

      row_diff = row_e - KM1_R;
      col_diff = col_e - KM1_C;
      emit     = acc && (row_e >= KM1_R) && (S == 1 || !row_diff[0])
                     && (col_e >= KM1_C) && (S == 1 || !col_diff[0]);
      hs_first = emit && (col_e == KM1_C) && (ch_e == '0);
      addr     = AW'(col_e) * AW'(CHANNEL) + AW'(ch_e);
   end

   always_ff @(posedge i_sclk or negedge i_rstn) begin
      if (!i_rstn) begin
         active_q <= 1'b0;
         row_q    <= '0;
         col_q    <= '0;
         ch_q     <= '0;
      end else begin
         active_q <= active_d;
         row_q    <= row_d;
         col_q    <= col_d;
         ch_q     <= ch_d;
      end
   end

   // ---------------- stage 1: line RAM read / vertical max ----------------
   logic               acc1_q, emit1_q, hs1_q;
   logic [WIDTH_D-1:0] word1_q;
   logic [AW-1:0]      addr1_q;
   logic [CW-1:0]      ch1_q;
   logic [WIDTH_D-1:0] rd_data [K-1];
   logic [WIDTH_D-1:0] vmax1;

   always_ff @(posedge i_sclk or negedge i_rstn) begin
      if (!i_rstn) begin
         acc1_q  <= 1'b0;
         emit1_q <= 1'b0;
         hs1_q   <= 1'b0;
         word1_q <= '0;
         addr1_q <= '0;
         ch1_q   <= '0;
      end else begin
         acc1_q  <= acc;
         emit1_q <= emit;
         hs1_q   <= hs_first;
         word1_q <= io.i_tdata;
         addr1_q <= addr;
         ch1_q   <= ch_e;
      end
   end

   // Each RAM is read one cycle before it is overwritten at the same address,
   // so RAMj hands its old row down to RAMj+1 while taking the newer one.
   for (genvar j = 0; j < K - 1; j++) begin : g_line
      logic [WIDTH_D-1:0] mem [DEPTH];
      logic [WIDTH_D-1:0] rd_q;
      logic [WIDTH_D-1:0] wr_data;

      if (j == 0) begin : g_head
         assign wr_data = word1_q;
      end else begin : g_tail
         assign wr_data = rd_data[j-1];
      end

      always_ff @(posedge i_sclk) begin
         if (acc)    rd_q <= mem[addr];
         if (acc1_q) mem[addr1_q] <= wr_data;
      end

      assign rd_data[j] = rd_q;
   end

   always_comb begin
      vmax1 = word1_q;
      for (int j = 0; j < K - 1; j++) vmax1 = mx(vmax1, rd_data[j]);
   end

   // ---------------- stage 2: horizontal max ----------------
   logic               acc2_q, emit2_q;
   logic [WIDTH_D-1:0] vmax2_q;
   logic [CW-1:0]      ch2_q;
   logic [WIDTH_D-1:0] stash_q [K-1][CHANNEL];
   logic [WIDTH_D-1:0] hmax2;

   always_ff @(posedge i_sclk or negedge i_rstn) begin
      if (!i_rstn) begin
         acc2_q  <= 1'b0;
         emit2_q <= 1'b0;
         vmax2_q <= '0;
         ch2_q   <= '0;
      end else begin
         acc2_q  <= acc1_q;
         emit2_q <= emit1_q;
         vmax2_q <= vmax1;
         ch2_q   <= ch1_q;
      end
   end

   always_comb begin
      hmax2 = vmax2_q;
      for (int j = 0; j < K - 1; j++) hmax2 = mx(hmax2, stash_q[j][ch2_q]);
   end

   always_ff @(posedge i_sclk) begin
      if (acc2_q) begin
         stash_q[0][ch2_q] <= vmax2_q;
         for (int j = 1; j < K - 1; j++) stash_q[j][ch2_q] <= stash_q[j-1][ch2_q];
      end
   end

   // ---------------- outputs ----------------
   logic               o_valid_q, o_hsync_q;
   logic [WIDTH_D-1:0] o_tdata_q;
   logic [2:0]         vs_sh_q;

   always_ff @(posedge i_sclk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_valid_q <= 1'b0;
         o_hsync_q <= 1'b0;
         o_tdata_q <= '0;
         vs_sh_q   <= '0;
      end else begin
         o_valid_q <= emit2_q;
         o_tdata_q <= emit2_q ? hmax2 : '0;
         o_hsync_q <= hs1_q;
         vs_sh_q   <= {vs_sh_q[1:0], io.i_vsync};
      end
   end

   assign io.o_valid = o_valid_q;
   assign io.o_tdata = o_tdata_q;
   assign io.o_hsync = o_hsync_q;
   assign io.o_vsync = vs_sh_q[2];

endmodule

// File: tb/tb_maxpool_line_cache_kxs.sv
// Bench for maxpool_line_cache_kxs: three configurations share one input stream; a window
// model over the stored frame predicts every output cycle, and literal lists pin the model.
module tb_maxpool_line_cache_kxs;
   localparam int W  = 27;
   localparam int SZ = 4;
   localparam int CH = 2;
   localparam int BIG = 1000;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         vs = 1'b0, hs = 1'b0, vd = 1'b0;
   logic [W-1:0] dt = '0;

   maxpool_line_cache_kxs_if #(.WIDTH_D(W)) if_a ();
   maxpool_line_cache_kxs_if #(.WIDTH_D(W)) if_b ();
   maxpool_line_cache_kxs_if #(.WIDTH_D(W)) if_c ();

   assign if_a.i_vsync = vs; assign if_a.i_hsync = hs; assign if_a.i_valid = vd; assign if_a.i_tdata = dt;
   assign if_b.i_vsync = vs; assign if_b.i_hsync = hs; assign if_b.i_valid = vd; assign if_b.i_tdata = dt;
   assign if_c.i_vsync = vs; assign if_c.i_hsync = hs; assign if_c.i_valid = vd; assign if_c.i_tdata = dt;

   maxpool_line_cache_kxs #(.WIDTH_D(W), .SIZE(SZ), .CHANNEL(CH), .K(2), .S(2), .SIGNED(1))
      dut_a (.i_sclk(clk), .i_rstn(rstn), .io(if_a));
   maxpool_line_cache_kxs #(.WIDTH_D(W), .SIZE(SZ), .CHANNEL(CH), .K(3), .S(1), .SIGNED(1))
      dut_b (.i_sclk(clk), .i_rstn(rstn), .io(if_b));
   maxpool_line_cache_kxs #(.WIDTH_D(W), .SIZE(SZ), .CHANNEL(CH), .K(2), .S(2), .SIGNED(0))
      dut_c (.i_sclk(clk), .i_rstn(rstn), .io(if_c));

   logic         ov [3], oh [3], ovs [3];
   logic [W-1:0] od [3];
   assign ov[0] = if_a.o_valid; assign oh[0] = if_a.o_hsync; assign ovs[0] = if_a.o_vsync; assign od[0] = if_a.o_tdata;
   assign ov[1] = if_b.o_valid; assign oh[1] = if_b.o_hsync; assign ovs[1] = if_b.o_vsync; assign od[1] = if_b.o_tdata;
   assign ov[2] = if_c.o_valid; assign oh[2] = if_c.o_hsync; assign ovs[2] = if_c.o_vsync; assign od[2] = if_c.o_tdata;

   int mk [3] = '{2, 3, 2};
   int ms [3] = '{2, 1, 2};
   int msg[3] = '{1, 1, 0};

   int errs = 0;
   int checks = 0;
   bit en = 1'b0;
   bit tb_active = 1'b0;

   logic [W-1:0] img [SZ][SZ][CH];
   logic [W-1:0] exp_d [int];
   bit           exp_h [int];
   bit           exp_v [int];

   logic [W-1:0] cap0 [$], cap1 [$], cap2 [$];
   int           hcnt [3];

   logic [W-1:0] ramp_a [8] = '{27'd20, 27'd21, 27'd28, 27'd29, 27'd52, 27'd53, 27'd60, 27'd61};
   logic [W-1:0] ramp_b [8] = '{27'd40, 27'd41, 27'd44, 27'd45, 27'd56, 27'd57, 27'd60, 27'd61};
   logic [W-1:0] sgn_lo [4] = '{27'h7FFFFFB, 27'h0000003, 27'h7FFFFFD, 27'h7FFFFF8};
   logic [W-1:0] sgn_hi [4] = '{27'h7FFFFFF, 27'h7FFFFFB, 27'h7FFFFFD, 27'h7FFFFF8};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   function automatic logic [W-1:0] mx(input logic [W-1:0] a, input logic [W-1:0] b, input int sg);
      if (sg != 0) return ($signed(a) > $signed(b)) ? a : b;
      return (a > b) ? a : b;
   endfunction

   function automatic logic [W-1:0] val(input int kind, input int r, input int c, input int ch);
      int p;
      p = (r % 2) * 2 + (c % 2);
      if (kind == 0) return W'(r * 16 + c * 4 + ch);
      return (r < 2) ? sgn_lo[p] : sgn_hi[p];
   endfunction

   // One input cycle; the model records the word and predicts outputs of every configuration.
   task automatic drive(input bit v_s, input bit h_s, input bit v, input logic [W-1:0] x,
                        input int r, input int c, input int ch);
      logic [W-1:0] m;
      int k, s;
      vs = v_s; hs = h_s; vd = v; dt = x;
      if (v_s) begin
         tb_active = 1'b1;
         exp_v[cyc + 3] = 1'b1;
      end
      if (v && tb_active) begin
         img[r][c][ch] = x;
         for (int d = 0; d < 3; d++) begin
            k = mk[d]; s = ms[d];
            if (r >= k - 1 && (r - k + 1) % s == 0 && c >= k - 1 && (c - k + 1) % s == 0) begin
               m = x;
               for (int dr = 0; dr < k; dr++)
                  for (int dc = 0; dc < k; dc++)
                     m = mx(m, img[r-dr][c-dc][ch], msg[d]);
               exp_d[d * 100000 + cyc + 3] = m;
               if (c == k - 1 && ch == 0) exp_h[d * 100000 + cyc + 2] = 1'b1;
            end
         end
      end
      @(posedge clk); #1;
      vs = 1'b0; hs = 1'b0; vd = 1'b0; dt = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 0, '0, 0, 0, 0);
   endtask

   task automatic send_frame(input int kind, input bit gaps, input int limit, input bit with_vs);
      int sent = 0;
      if (with_vs) drive(1, 0, 0, '0, 0, 0, 0);
      for (int r = 0; r < SZ; r++) begin
         if (sent >= limit) return;
         drive(0, 1, 0, '0, 0, 0, 0);
         for (int c = 0; c < SZ; c++)
            for (int ch = 0; ch < CH; ch++) begin
               if (sent >= limit) return;
               if (gaps && $urandom_range(0, 1) == 1) idle(1);
               drive(0, 0, 1, val(kind, r, c, ch), r, c, ch);
               sent++;
            end
      end
   endtask

   task automatic clear_caps();
      cap0.delete(); cap1.delete(); cap2.delete();
      for (int d = 0; d < 3; d++) hcnt[d] = 0;
   endtask

   task automatic check_ramp(input int nframes);
      chk("ramp_a_count", cap0.size(), 8 * nframes);
      chk("ramp_b_count", cap1.size(), 8 * nframes);
      chk("ramp_a_hsyncs", hcnt[0], 2 * nframes);
      chk("ramp_b_hsyncs", hcnt[1], 2 * nframes);
      for (int i = 0; i < cap0.size() && i < 8 * nframes; i++)
         chk($sformatf("ramp_a[%0d]", i), cap0[i], ramp_a[i % 8]);
      for (int i = 0; i < cap1.size() && i < 8 * nframes; i++)
         chk($sformatf("ramp_b[%0d]", i), cap1[i], ramp_b[i % 8]);
   endtask

   // Cycle-exact compare of every configuration against the model.
   always @(negedge clk) begin
      if (en) begin
         for (int d = 0; d < 3; d++) begin
            int key;
            bit ev;
            logic [W-1:0] ed;
            key = d * 100000 + cyc;
            ev  = exp_d.exists(key);
            ed  = ev ? exp_d[key] : '0;
            chk($sformatf("dut%0d_o_valid", d), 32'(ov[d]), 32'(ev));
            chk($sformatf("dut%0d_o_tdata", d), 32'(od[d]), 32'(ed));
            chk($sformatf("dut%0d_o_hsync", d), 32'(oh[d]), 32'(exp_h.exists(key)));
            chk($sformatf("dut%0d_o_vsync", d), 32'(ovs[d]), 32'(exp_v.exists(cyc)));
            if (ov[d]) begin
               if (d == 0) cap0.push_back(od[d]);
               else if (d == 1) cap1.push_back(od[d]);
               else cap2.push_back(od[d]);
            end
            if (oh[d]) hcnt[d]++;
         end
      end
   end

   initial begin
      clear_caps();
      #2 rstn = 1'b0;
      @(posedge clk); #1;
      en = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      chk("reset_o_valid", 32'(if_a.o_valid), 0);
      chk("reset_o_tdata", 32'(if_a.o_tdata), 0);
      chk("reset_o_hsync", 32'(if_b.o_hsync), 0);
      chk("reset_o_vsync", 32'(if_c.o_vsync), 0);
      rstn = 1'b1;
      idle(2);

      // plain ramp
      clear_caps();
      send_frame(0, 0, BIG, 1);
      idle(6);
      check_ramp(1);

      // gapped ramp, then back-to-back aborted frame, then full ramp
      clear_caps();
      send_frame(0, 1, BIG, 1);
      send_frame(0, 0, SZ * CH + 1, 1);
      send_frame(0, 0, BIG, 1);
      idle(6);
      check_ramp(2);

      // signed vs unsigned compare
      clear_caps();
      send_frame(1, 0, BIG, 1);
      idle(6);
      chk("sign_a_count", cap0.size(), 8);
      chk("sign_c_count", cap2.size(), 8);
      if (cap0.size() >= 5 && cap2.size() >= 5) begin
         chk("signed_win0", cap0[0], 27'h0000003);
         chk("unsigned_win0", cap2[0], 27'h7FFFFFD);
         chk("signed_win2", cap0[4], 27'h7FFFFFF);
         chk("unsigned_win2", cap2[4], 27'h7FFFFFF);
      end

      // reset in the middle of row 2
      send_frame(0, 0, 2 * SZ * CH + 3, 1);
      rstn = 1'b0;
      exp_d.delete(); exp_h.delete(); exp_v.delete();
      tb_active = 1'b0;
      #1;
      chk("midreset_o_valid", 32'(if_b.o_valid), 0);
      chk("midreset_o_tdata", 32'(if_b.o_tdata), 0);
      repeat (2) begin @(posedge clk); #1; end
      rstn = 1'b1;
      clear_caps();
      send_frame(0, 0, BIG, 0);
      idle(6);
      chk("no_vsync_a_count", cap0.size(), 0);
      chk("no_vsync_b_count", cap1.size(), 0);
      clear_caps();
      send_frame(0, 0, BIG, 1);
      idle(6);
      check_ramp(1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
